// File: rtl/fs_npc_redirect_pkg.sv
// Shared constants for the pre-fetch next-PC generator: branch bus layout,
// BTB geometry defaults and the redirect FSM state encoding.
package fs_npc_redirect_pkg;

   localparam logic [31:0] RESET_PC    = 32'hBFC0_0000;
   localparam int          BTB_ENTRIES = 16;

   localparam int BR_BUS_WD   = 33;
   localparam int PRD_ERR_BIT = 32;
   localparam int TARGET_MSB  = 31;

   function automatic int btb_idx_w(input int entries);
      return $clog2(entries);
   endfunction

   localparam int BTB_IDX_W = btb_idx_w(BTB_ENTRIES);
   localparam int BTB_TAG_W = 32 - BTB_IDX_W - 2;

   localparam logic [1:0] SEQ   = 2'd0;
   localparam logic [1:0] DSLOT = 2'd1;
   localparam logic [1:0] REDIR = 2'd2;

endpackage

// File: rtl/fs_npc_redirect_btb_dm.sv
// Direct-mapped branch target buffer: combinational read, one synchronous
// write port. A same-cycle read of the slot being written sees the old entry.
module btb_dm #(
   parameter int IDX_W = 4,
   parameter int TAG_W = 26
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic [IDX_W-1:0] rd_idx,
   input  logic [TAG_W-1:0] rd_tag,
   output logic             rd_hit,
   output logic [31:0]      rd_target,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic [TAG_W-1:0] wr_tag,
   input  logic [31:0]      wr_target
);

   localparam int ENTRIES = 1 << IDX_W;

   logic [ENTRIES-1:0] valid_q;
   logic [TAG_W-1:0]   tag_q    [ENTRIES];
   logic [31:0]        target_q [ENTRIES];

   // Only the valid bits are cleared; stale tag/target contents are harmless.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         valid_q <= '0;
      end else if (wr_en) begin
         valid_q[wr_idx] <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         tag_q[wr_idx]    <= wr_tag;
         target_q[wr_idx] <= wr_target;
      end
   end

   assign rd_hit    = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
   assign rd_target = target_q[rd_idx];

endmodule

// File: rtl/fs_npc_redirect.sv
// Pre-fetch next-PC generator: owns the fetch PC, predicts through a small
// BTB (branch + delay slot), and redirects on execute-stage mispredicts.
module fs_npc_redirect #(
   parameter int          BTB_ENTRIES = fs_npc_redirect_pkg::BTB_ENTRIES,
   parameter logic [31:0] RESET_PC    = fs_npc_redirect_pkg::RESET_PC
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        es_valid,
   input  logic [32:0] es_br_bus,
   input  logic        es_b_or_j,
   input  logic [31:0] es_pc,
   input  logic        fs_allowin,
   output logic        pfs_valid,
   output logic [31:0] pfs_pc,
   output logic [31:0] pfs_pd_pc,
   output logic        br_flush,
   output logic [1:0]  dbg_state
);

   import fs_npc_redirect_pkg::*;

   localparam int IDX_W = $clog2(BTB_ENTRIES);
   localparam int TAG_W = 32 - IDX_W - 2;

   // Handshake: the fetch stage takes pfs_pc on a cycle where
   // pfs_valid & fs_allowin; the PC only advances when fs_allowin is high.

   logic [1:0]  state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] pend_pc_q, pend_pc_d;
   logic [31:0] tgt_q, tgt_d;

   logic        redirect;
   logic [31:0] real_target;
   logic        btb_hit;
   logic [31:0] btb_target;
   logic        btb_wr;

   assign redirect    = es_valid & es_br_bus[PRD_ERR_BIT];
   assign real_target = es_br_bus[TARGET_MSB:0];
   assign btb_wr      = es_valid & es_b_or_j;

   btb_dm #(
      .IDX_W (IDX_W),
      .TAG_W (TAG_W)
   ) u_btb (
      .clk       (clk),
      .resetn    (resetn),
      .rd_idx    (pc_q[IDX_W+1:2]),
      .rd_tag    (pc_q[31:IDX_W+2]),
      .rd_hit    (btb_hit),
      .rd_target (btb_target),
      .wr_en     (btb_wr),
      .wr_idx    (es_pc[IDX_W+1:2]),
      .wr_tag    (es_pc[31:IDX_W+2]),
      .wr_target (real_target)
   );

   // A mispredict always wins; a stalled one parks its target in pend_pc.
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      pend_pc_d = pend_pc_q;
      tgt_d     = tgt_q;
      if (redirect && fs_allowin) begin
         pc_d    = real_target;
         state_d = SEQ;
      end else if (redirect) begin
         pend_pc_d = real_target;
         state_d   = REDIR;
      end else if (fs_allowin) begin
         case (state_q)
            REDIR: begin
               pc_d    = pend_pc_q;
               state_d = SEQ;
            end
            DSLOT: begin
               pc_d    = tgt_q;
               state_d = SEQ;
            end
            default: begin
               pc_d = pc_q + 32'd4;
               if (btb_hit) begin
                  tgt_d   = btb_target;
                  state_d = DSLOT;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q   <= SEQ;
         pc_q      <= RESET_PC;
         pend_pc_q <= 32'd0;
         tgt_q     <= 32'd0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         pend_pc_q <= pend_pc_d;
         tgt_q     <= tgt_d;
      end
   end

   assign pfs_valid = resetn & (state_q != REDIR);
   assign pfs_pc    = pc_q;
   assign pfs_pd_pc = btb_hit ? btb_target : (pc_q + 32'd8);
   assign br_flush  = resetn & redirect;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_fs_npc_redirect.sv
// Bench for fs_npc_redirect: directed vector table, then random stimulus
// checked against a queue/array-based model of the fetch PC stream.
module tb_fs_npc_redirect;
   import fs_npc_redirect_pkg::*;

   localparam int IW = 4;

   logic        clk = 1'b0;
   logic        resetn;
   logic        es_valid;
   logic [32:0] es_br_bus;
   logic        es_b_or_j;
   logic [31:0] es_pc;
   logic        fs_allowin;
   logic        pfs_valid;
   logic [31:0] pfs_pc;
   logic [31:0] pfs_pd_pc;
   logic        br_flush;
   logic [1:0]  dbg_state;

   int checks = 0;
   int errors = 0;

   fs_npc_redirect dut (
      .clk        (clk),
      .resetn     (resetn),
      .es_valid   (es_valid),
      .es_br_bus  (es_br_bus),
      .es_b_or_j  (es_b_or_j),
      .es_pc      (es_pc),
      .fs_allowin (fs_allowin),
      .pfs_valid  (pfs_valid),
      .pfs_pc     (pfs_pc),
      .pfs_pd_pc  (pfs_pd_pc),
      .br_flush   (br_flush),
      .dbg_state  (dbg_state)
   );

   // clock / reset
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   // driver
   task automatic drive(input logic ev, input logic perr, input logic [31:0] tgt,
                        input logic bj, input logic [31:0] epc, input logic alw);
      es_valid   = ev;
      es_br_bus  = {perr, tgt};
      es_b_or_j  = bj;
      es_pc      = epc;
      fs_allowin = alw;
   endtask

   typedef struct {
      logic        ev;
      logic        perr;
      logic [31:0] tgt;
      logic        bj;
      logic [31:0] epc;
      logic        alw;
      logic        e_valid;
      logic [31:0] e_pc;
      logic [31:0] e_pd;
      logic        e_flush;
      logic [1:0]  e_st;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic ev, logic perr, logic [31:0] tgt, logic bj,
                               logic [31:0] epc, logic alw, logic e_valid,
                               logic [31:0] e_pc, logic [31:0] e_pd, logic e_flush,
                               logic [1:0] e_st);
      vec_t v;
      v.ev = ev; v.perr = perr; v.tgt = tgt; v.bj = bj; v.epc = epc; v.alw = alw;
      v.e_valid = e_valid; v.e_pc = e_pc; v.e_pd = e_pd; v.e_flush = e_flush; v.e_st = e_st;
      return v;
   endfunction

   // behavioural reference model
   logic [31:0] m_pc;
   bit          m_wait;
   logic [31:0] m_wait_pc;
   logic [31:0] m_owed_q[$];
   bit          b_v   [1<<IW];
   logic [31:0] b_pc  [1<<IW];
   logic [31:0] b_tgt [1<<IW];

   function automatic int m_idx(logic [31:0] a);
      return int'((a >> 2) % (1 << IW));
   endfunction

   function automatic bit m_hit(logic [31:0] a);
      int i = m_idx(a);
      return b_v[i] && ((b_pc[i] >> (IW + 2)) == (a >> (IW + 2)));
   endfunction

   task automatic m_reset();
      m_pc = RESET_PC;
      m_wait = 0;
      m_wait_pc = 32'd0;
      m_owed_q.delete();
      for (int i = 0; i < (1 << IW); i++) b_v[i] = 0;
   endtask

   task automatic m_step(input logic ev, input logic perr, input logic [31:0] tgt,
                         input logic bj, input logic [31:0] epc, input logic alw);
      bit hit = m_hit(m_pc);
      logic [31:0] ht = b_tgt[m_idx(m_pc)];
      if (ev && perr) begin
         m_owed_q.delete();
         if (alw) begin
            m_pc = tgt;
            m_wait = 0;
         end else begin
            m_wait = 1;
            m_wait_pc = tgt;
         end
      end else if (m_wait) begin
         if (alw) begin
            m_pc = m_wait_pc;
            m_wait = 0;
         end
      end else if (alw) begin
         if (m_owed_q.size() != 0) begin
            m_pc = m_owed_q.pop_front();
         end else begin
            if (hit) m_owed_q.push_back(ht);
            m_pc = m_pc + 32'd4;
         end
      end
      if (ev && bj) begin
         b_v[m_idx(epc)]   = 1;
         b_pc[m_idx(epc)]  = epc;
         b_tgt[m_idx(epc)] = tgt;
      end
   endtask

   task automatic apply_vec(input vec_t v, input int n);
      drive(v.ev, v.perr, v.tgt, v.bj, v.epc, v.alw);
      #1;
      chk($sformatf("v%0d_valid", n), 32'(pfs_valid), 32'(v.e_valid));
      chk($sformatf("v%0d_pc", n), pfs_pc, v.e_pc);
      chk($sformatf("v%0d_pd", n), pfs_pd_pc, v.e_pd);
      chk($sformatf("v%0d_flush", n), 32'(br_flush), 32'(v.e_flush));
      chk($sformatf("v%0d_state", n), 32'(dbg_state), 32'(v.e_st));
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      resetn = 1'b0;
      drive(1'b1, 1'b1, 32'h1234_5678, 1'b1, 32'h0, 1'b1);

      // sequential fetch after reset, BTB training at BFC00010
      vecs.push_back(mk(0,0,32'h0,0,32'h0,1, 1,32'hBFC00000,32'hBFC00008,0,SEQ));
      vecs.push_back(mk(1,0,32'hBFC00100,1,32'hBFC00010,1, 1,32'hBFC00004,32'hBFC0000C,0,SEQ));
      vecs.push_back(mk(0,0,32'h0,0,32'h0,1, 1,32'hBFC00008,32'hBFC00010,0,SEQ));
      vecs.push_back(mk(0,0,32'h0,0,32'h0,1, 1,32'hBFC0000C,32'hBFC00014,0,SEQ));
      vecs.push_back(mk(0,0,32'h0,0,32'h0,1, 1,32'hBFC00010,32'hBFC00100,0,SEQ));
      vecs.push_back(mk(0,0,32'h0,0,32'h0,1, 1,32'hBFC00014,32'hBFC0001C,0,DSLOT));
      // mispredict without stall
      vecs.push_back(mk(1,1,32'h80001000,1,32'hBFC00018,1, 1,32'hBFC00100,32'hBFC00108,1,SEQ));
      // two redirects under stall, the second wins
      vecs.push_back(mk(1,1,32'h80002000,1,32'hBFC00020,0, 1,32'h80001000,32'h80001008,1,SEQ));
      vecs.push_back(mk(1,1,32'h80003000,0,32'h0,0, 0,32'h80001000,32'h80001008,1,REDIR));
      vecs.push_back(mk(0,0,32'h0,0,32'h0,0, 0,32'h80001000,32'h80001008,0,REDIR));
      vecs.push_back(mk(0,0,32'h0,0,32'h0,1, 0,32'h80001000,32'h80001008,0,REDIR));
      // train 80003008 -> 80005000, then redirect during its delay slot
      vecs.push_back(mk(1,0,32'h80005000,1,32'h80003008,1, 1,32'h80003000,32'h80003008,0,SEQ));
      vecs.push_back(mk(0,0,32'h0,0,32'h0,1, 1,32'h80003004,32'h8000300C,0,SEQ));
      vecs.push_back(mk(0,0,32'h0,0,32'h0,1, 1,32'h80003008,32'h80005000,0,SEQ));
      vecs.push_back(mk(1,1,32'h80004000,1,32'h80003008,1, 1,32'h8000300C,32'h80003014,1,DSLOT));
      vecs.push_back(mk(0,0,32'h0,0,32'h0,1, 1,32'h80004000,32'h80004008,0,SEQ));
      // tgt_q is never fetched; redirect back to BFC00010 for the collision case
      vecs.push_back(mk(1,1,32'hBFC00010,0,32'h0,1, 1,32'h80004004,32'h8000400C,1,SEQ));
      vecs.push_back(mk(1,0,32'h80000200,1,32'h80000010,0, 1,32'hBFC00010,32'hBFC00100,0,SEQ));
      vecs.push_back(mk(1,1,32'h80000010,0,32'h0,1, 1,32'hBFC00010,32'hBFC00018,1,SEQ));
      vecs.push_back(mk(0,0,32'h0,0,32'h0,0, 1,32'h80000010,32'h80000200,0,SEQ));
      // 32-bit wrap of pc+4 / pc+8
      vecs.push_back(mk(1,1,32'hFFFFFFFC,0,32'h0,1, 1,32'h80000010,32'h80000200,1,SEQ));
      vecs.push_back(mk(0,0,32'h0,0,32'h0,1, 1,32'hFFFFFFFC,32'h00000004,0,SEQ));
      vecs.push_back(mk(0,0,32'h0,0,32'h0,1, 1,32'h00000000,32'h00000008,0,SEQ));

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_valid", 32'(pfs_valid), 32'd0);
      chk("rst_flush", 32'(br_flush), 32'd0);
      chk("rst_pc", pfs_pc, 32'hBFC00000);
      resetn = 1'b1;

      for (int i = 0; i < vecs.size(); i++) apply_vec(vecs[i], i);

      // randomized phase against the model
      resetn = 1'b0;
      drive(0, 0, 32'h0, 0, 32'h0, 0);
      m_reset();
      @(posedge clk);
      @(negedge clk);
      resetn = 1'b1;
      for (int n = 0; n < 3000; n++) begin
         logic ev, perr, bj, alw;
         logic [31:0] tgt, epc;
         bit hit;
         ev   = ($urandom_range(0, 2) != 0);
         perr = ($urandom_range(0, 4) == 0);
         bj   = ($urandom_range(0, 1) != 0);
         alw  = ($urandom_range(0, 3) != 0);
         epc  = 32'h0040_0000 + {24'd0, 6'($urandom_range(0, 63)), 2'b00};
         tgt  = ($urandom_range(0, 15) == 0) ? $urandom()
                : 32'h0040_0000 + {24'd0, 6'($urandom_range(0, 63)), 2'b00};
         drive(ev, perr, tgt, bj, epc, alw);
         #1;
         hit = m_hit(m_pc);
         chk("rnd_valid", 32'(pfs_valid), 32'(!m_wait));
         chk("rnd_pc", pfs_pc, m_pc);
         chk("rnd_pd", pfs_pd_pc, hit ? b_tgt[m_idx(m_pc)] : m_pc + 32'd8);
         chk("rnd_flush", 32'(br_flush), 32'(ev && perr));
         @(posedge clk);
         m_step(ev, perr, tgt, bj, epc, alw);
         @(negedge clk);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fs_npc_redirect.md
Name: fs_npc_redirect

Overview:
- Pre-fetch next-PC generator for the dual-issue MIPS core.
- Receiving end of the execute-stage branch bus: consumes {prd_err, real_target} plus the resolved branch PC from the execute sub-pipe.
- Owns the fetch PC register and a small direct-mapped BTB.
- Presents one fetch PC per cycle to the fetch stage, with a predicted target that travels down the pipe and later returns as es_pd_pc.

Parameters:
- BTB_ENTRIES, 16, number of BTB entries (power of two).
- RESET_PC, 32'hBFC0_0000, fetch PC after reset.

Ports:
- clk  in  1  core clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- es_valid  in  1  execute slot holds a valid instruction.
- es_br_bus  in  33  {prd_err[32], real_target[31:0]} from execute.
- es_b_or_j  in  1  execute instruction is a branch/jump.
- es_pc  in  32  PC of the execute-stage branch.
- fs_allowin  in  1  fetch stage accepts pfs_pc this cycle.
- pfs_valid  out  1  pfs_pc is a valid fetch request.
- pfs_pc  out  32  current fetch PC.
- pfs_pd_pc  out  32  predicted target for the instruction at pfs_pc.
- br_flush  out  1  kill younger wrong-path fetch/decode entries.

Behaviour:
- Reset (resetn=0, async):
  - pc=RESET_PC, state=SEQ, all BTB valid bits=0.
  - pend_pc=0, tgt_q=0.
  - pfs_valid=0, br_flush=0.
- Event R = es_valid & es_br_bus[32]. br_flush = R, combinational, one cycle per event. br_flush is 0 during reset.
- BTB structure:
  - index = pc[idx+1:2], tag = pc[31:idx+2], idx = log2(BTB_ENTRIES).
  - Lookup is combinational on pfs_pc. hit = valid & tag match.
- pfs_pd_pc = hit ? btb_target : pfs_pc+8 (not-taken target skips the delay slot).
- BTB update:
  - Condition: es_valid & es_b_or_j, independent of R. Writes {valid=1, tag(es_pc), es_br_bus[31:0]} at index(es_pc) on the clock edge.
  - A same-cycle lookup of the same index returns the old contents (no bypass).
- States: SEQ, DSLOT, REDIR. pfs_valid = 1 in SEQ and DSLOT after reset release, 0 in REDIR.
- Transitions, in priority order:
  1. R & fs_allowin: pc<=real_target, state<=SEQ. Any pending DSLOT target is discarded.
  2. R & !fs_allowin: pend_pc<=real_target, state<=REDIR. A new R while in REDIR overwrites pend_pc.
  3. REDIR & fs_allowin & !R: pc<=pend_pc, state<=SEQ.
  4. SEQ & fs_allowin & hit: pc<=pc+4 (delay slot), tgt_q<=btb_target, state<=DSLOT.
  5. SEQ & fs_allowin & !hit: pc<=pc+4.
  6. DSLOT & fs_allowin: pc<=tgt_q, state<=SEQ. The BTB hit on the delay-slot PC is ignored.
  7. Otherwise: hold pc and state.
- Arithmetic:
  - pc+4 and pc+8 are 32-bit and wrap modulo 2^32.
  - pc[1:0] is always taken from its source; no alignment check here. Address exceptions are raised downstream.
- Latency:
  - Redirect PC appears on pfs_pc the cycle after R when fs_allowin=1.
  - Otherwise it appears the cycle after the first fs_allowin.
- Delay-slot instructions already fetched are older than the branch's wrong path. Their retention is decided by the br_flush consumer, not here.

Decomposition:
- Shared package/header:
  - RESET_PC.
  - BR_BUS_WD=33, with field positions PRD_ERR_BIT=32 and TARGET_MSB=31.
  - BTB_IDX_W and BTB_TAG_W derived from BTB_ENTRIES.
  - State encoding SEQ/DSLOT/REDIR.
- One sub-module, btb_dm:
  - Direct-mapped BTB with async-clear valid array.
  - Combinational read port and a single synchronous write port.
  - Write-then-read-old ordering.
- FSM and PC muxing stay in fs_npc_redirect.

Test Plan:
- Reset then fs_allowin=1, no branches:
  - pfs_valid=0 during reset.
  - pfs_pc sequence BFC00000, BFC00004, BFC00008.
  - pfs_pd_pc = pfs_pc+8 throughout.
- BTB train and hit:
  - Stimulus: es_valid=1, es_b_or_j=1, es_pc=BFC00010, target=BFC00100, prd_err=0.
  - When pfs_pc later reaches BFC00010: pfs_pd_pc=BFC00100.
  - Next cycles: pfs_pc=BFC00014, then BFC00100.
- Mispredict, no stall: R with target=80001000 while fs_allowin=1 → br_flush=1 for that cycle, pfs_pc=80001000 the next cycle, state=SEQ.
- Redirect under stall:
  - R (target 80002000) with fs_allowin=0, then R (target 80003000) one cycle later, still stalled.
  - Required: pfs_valid=0 while stalled.
  - On fs_allowin=1, pfs_pc=80003000 the following cycle.
- Redirect during DSLOT: BTB hit at pc A, R (target 80004000) arrives in the DSLOT cycle → pfs_pc=80004000 and tgt_q is never fetched.
- Same-index collision:
  - Update at index 4 with a new tag in the same cycle as a lookup of the old tag at index 4.
  - Required: the lookup hits with the old target; the next lookup of the old tag misses (pfs_pd_pc=pc+8).
